// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-wide, combinational-read data memory.
// Word-aligned memory accesses only; sub-word stores are read-modify-write.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_memwrite,
    input  logic [31:0] mem_rd
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRmwRead,
        StWrite,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    // Holds the store data at accept and the merged word once RMW_READ has run.
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        funct3_err;
    logic        align_err;
    logic        range_err;
    logic        req_err;
    logic [32:0] end_addr;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;
    logic [31:0] merged;

    // Request checking on the live inputs; only consulted on the accept edge.
    always_comb begin
        funct3_err = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                     (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
        align_err  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        end_addr   = {1'b0, req_addr[31:2], 2'b00} + 33'd3;
        range_err  = end_addr >= 33'(MEM_BYTES);
        req_err    = funct3_err || align_err || range_err;
    end

    always_comb begin
        ld_byte = mem_rd[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (funct3_q)
            3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_value = {24'd0, ld_byte};
            3'b101:  ld_value = {16'd0, ld_half};
            default: ld_value = mem_rd;
        endcase
    end

    always_comb begin
        merged = mem_rd;
        if (funct3_q[1:0] == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    wdata_d  = req_wdata;
                    rdata_d  = 32'd0;
                    err_d    = req_err;
                    if (req_err) begin
                        state_d = StResp;
                    end else if (!req_we) begin
                        state_d = StLoad;
                    end else if (req_funct3[1:0] == 2'b10) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRmwRead;
                    end
                end
            end
            StLoad: begin
                rdata_d = ld_value;
                state_d = StResp;
            end
            StRmwRead: begin
                wdata_d = merged;
                state_d = StWrite;
            end
            StWrite: begin
                state_d = StResp;
            end
            StResp: begin
                rdata_d = 32'd0;
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= 32'd0;
            funct3_q <= 3'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Write strobe is a pure state decode so an async reset kills it immediately.
    assign req_ready    = (state_q == StIdle);
    assign resp_valid   = (state_q == StResp);
    assign resp_rdata   = rdata_q;
    assign resp_err     = err_q;
    assign mem_addr     = {addr_q[31:2], 2'b00};
    assign mem_memwrite = (state_q == StWrite);
    assign mem_wd       = mem_memwrite ? wdata_q : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-byte behavioural data memory (mem[i]=i).
// Expected values are hand-computed from the preload pattern.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_memwrite;
    logic [31:0] mem_rd;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.MEM_BYTES(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_memwrite (mem_memwrite),
        .mem_rd       (mem_rd)
    );

    always #5 clk = ~clk;

    // Behavioural data memory; reload restores mem[i]=i.
    logic [7:0] mem [0:63];
    logic       reload = 1'b1;
    logic [3:0] widx;
    assign widx   = mem_addr[5:2];
    assign mem_rd = {mem[{widx, 2'd3}], mem[{widx, 2'd2}], mem[{widx, 2'd1}], mem[{widx, 2'd0}]};

    always @(posedge clk) begin
        if (reload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
        end else if (mem_memwrite) begin
            mem[{widx, 2'd0}] <= mem_wd[7:0];
            mem[{widx, 2'd1}] <= mem_wd[15:8];
            mem[{widx, 2'd2}] <= mem_wd[23:16];
            mem[{widx, 2'd3}] <= mem_wd[31:24];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request from IDLE; returns response, latency in edges and write pulses seen.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                       output int lat, output int nwr, output logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        // Scramble inputs after accept; they must have no effect.
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b111;
        req_addr   = ~addr;
        req_wdata  = 32'h5A5A5A5A;
        lat = 0; nwr = 0; rdata = 32'd0; err = 1'b0; wd = 32'd0;
        for (int c = 1; c <= 10; c++) begin
            if (mem_memwrite) begin
                nwr++;
                wd = mem_wd;
            end
            if (resp_valid) begin
                lat   = c;
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] exp);
        logic [31:0] rd, wd;
        logic        er;
        int          lat, nwr;
        txn(1'b0, f3, addr, 32'd0, rd, er, lat, nwr, wd);
        check_eq({tag, " rdata"}, rd, exp);
        check_eq({tag, " err"}, 32'(er), 32'd0);
        check_eq({tag, " latency"}, lat, 2);
    endtask

    task automatic do_err(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr);
        logic [31:0] rd, wd;
        logic        er;
        int          lat, nwr;
        txn(we, f3, addr, 32'hFFFFFFFF, rd, er, lat, nwr, wd);
        check_eq({tag, " err"}, 32'(er), 32'd1);
        check_eq({tag, " rdata"}, rd, 32'd0);
        check_eq({tag, " latency"}, lat, 1);
        check_eq({tag, " writes"}, nwr, 0);
    endtask

    function automatic logic [31:0] orig_word(input int a);
        return {8'(a + 3), 8'(a + 2), 8'(a + 1), 8'(a)};
    endfunction

    initial begin
        logic [31:0] rd, wd;
        logic        er;
        int          lat, nwr;
        logic [31:0] exp_q[$];
        logic [31:0] a;

        repeat (2) @(posedge clk);
        #1;
        reload = 1'b0;
        check_eq("reset resp_valid", 32'(resp_valid), 32'd0);
        check_eq("reset resp_rdata", resp_rdata, 32'd0);
        check_eq("reset resp_err", 32'(resp_err), 32'd0);
        check_eq("reset memwrite", 32'(mem_memwrite), 32'd0);
        check_eq("reset mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle ready", 32'(req_ready), 32'd1);

        // 1. basic loads
        do_load("LW 0", 3'b010, 32'd0, 32'h03020100);
        do_load("LB 3", 3'b000, 32'd3, 32'h00000003);

        // 2. byte store then loads
        txn(1'b1, 3'b000, 32'd5, 32'h000000A5, rd, er, lat, nwr, wd);
        check_eq("SB 5 latency", lat, 3);
        check_eq("SB 5 writes", nwr, 1);
        check_eq("SB 5 mem_wd", wd, 32'h0706A504);
        check_eq("SB 5 err", 32'(er), 32'd0);
        check_eq("SB 5 rdata", rd, 32'd0);
        do_load("LW 4", 3'b010, 32'd4, 32'h0706A504);
        do_load("LB 5", 3'b000, 32'd5, 32'hFFFFFFA5);
        do_load("LBU 5", 3'b100, 32'd5, 32'h000000A5);

        // 3. half store on fresh memory
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        txn(1'b1, 3'b001, 32'd6, 32'h1234BEEF, rd, er, lat, nwr, wd);
        check_eq("SH 6 latency", lat, 3);
        check_eq("SH 6 writes", nwr, 1);
        check_eq("SH 6 mem_wd", wd, 32'hBEEF0504);
        do_load("LHU 6", 3'b101, 32'd6, 32'h0000BEEF);
        do_load("LH 6", 3'b001, 32'd6, 32'hFFFFBEEF);

        // 4. error cases and range boundary
        do_err("LW 2", 1'b0, 3'b010, 32'd2);
        do_err("LH 1", 1'b0, 3'b001, 32'd1);
        do_err("S f3=100", 1'b1, 3'b100, 32'd0);
        do_err("L f3=011", 1'b0, 3'b011, 32'd0);
        do_load("LW 60", 3'b010, 32'd60, 32'h3F3E3D3C);
        do_err("LW 64", 1'b0, 3'b010, 32'd64);
        do_err("SW 64", 1'b1, 3'b010, 32'd64);
        do_load("LW 0 again", 3'b010, 32'd0, 32'h03020100);

        // 5. reset during WRITE cancels the store
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'd8;
        req_wdata  = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("SW 8 in WRITE", 32'(mem_memwrite), 32'd1);
        check_eq("SW 8 mem_wd", mem_wd, 32'hDEADBEEF);
        #1;
        rst = 1'b1;
        #1;
        check_eq("rst memwrite drop", 32'(mem_memwrite), 32'd0);
        check_eq("rst mem_wd", mem_wd, 32'd0);
        check_eq("rst resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst resp_rdata", resp_rdata, 32'd0);
        check_eq("rst resp_err", 32'(resp_err), 32'd0);
        check_eq("rst mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_load("LW 8 after rst", 3'b010, 32'd8, 32'h0B0A0908);

        // 6. back-to-back with req_valid held high and addr changing every cycle
        for (int i = 0; i < 12; i++) begin
            a          = 32'(12 + 4 * (i % 7));
            req_valid  = 1'b1;
            req_we     = 1'b0;
            req_funct3 = 3'b010;
            req_addr   = a;
            check_eq($sformatf("b2b ready %0d", i), 32'(req_ready), 32'((i % 3) == 0));
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("b2b unexpected resp", 32'd1, 32'd0);
                end else begin
                    check_eq($sformatf("b2b rdata %0d", i), resp_rdata, exp_q.pop_front());
                end
            end
            if (req_ready) exp_q.push_back(orig_word(int'(a)));
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        repeat (3) begin
            if (resp_valid && exp_q.size() != 0) begin
                check_eq("b2b drain rdata", resp_rdata, exp_q.pop_front());
            end
            @(posedge clk);
            #1;
        end
        check_eq("b2b all served", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
